// File: rtl/div_seq_tc.sv
// div_seq_tc: iterative radix-2 restoring divider, signed or unsigned per operation.
// One division in flight; one quotient bit per cycle; valid/ready on input and output.
// Ports:
//   i_clk, i_rst_n              clock (rising edge), synchronous active-low reset
//   i_in_valid / o_in_ready     operand handshake; accepted only while idle
//   i_a, i_b, i_tc              dividend, divisor, 1 = two's-complement operands
//   o_out_valid / i_out_ready   result handshake; result held until taken
//   o_quot, o_rem               quotient (A_WIDTH), remainder (B_WIDTH)
//   o_div_by_zero, o_overflow   divisor was zero / signed MIN divided by -1
module div_seq_tc #(
    parameter int unsigned A_WIDTH = 16,
    parameter int unsigned B_WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [A_WIDTH-1:0] i_a,
    input  logic [B_WIDTH-1:0] i_b,
    input  logic               i_tc,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [A_WIDTH-1:0] o_quot,
    output logic [B_WIDTH-1:0] o_rem,
    output logic               o_div_by_zero,
    output logic               o_overflow
);

    localparam int unsigned CNT_W = (A_WIDTH > 1) ? $clog2(A_WIDTH) : 1;
    localparam logic [A_WIDTH-1:0] A_MIN = {1'b1, {(A_WIDTH-1){1'b0}}};
    localparam logic [B_WIDTH-1:0] B_ONES = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [A_WIDTH-1:0] a_q, a_d;         // operand as accepted
    logic [B_WIDTH-1:0] b_q, b_d;
    logic               tc_q, tc_d;
    logic [B_WIDTH-1:0] babs_q, babs_d;   // divisor magnitude
    logic [A_WIDTH-1:0] dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
    logic [B_WIDTH-1:0] prem_q, prem_d;   // partial remainder
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sgn_quot_q, sgn_quot_d;
    logic               sgn_rem_q, sgn_rem_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [A_WIDTH-1:0] quot_q, quot_d;
    logic [B_WIDTH-1:0] rem_q, rem_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;

    logic [B_WIDTH:0]   rem_sh;
    logic               trial_ge;

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            tc_q       <= 1'b0;
            babs_q     <= '0;
            dvd_q      <= '0;
            prem_q     <= '0;
            cnt_q      <= '0;
            sgn_quot_q <= 1'b0;
            sgn_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            ovf_pend_q <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            tc_q       <= tc_d;
            babs_q     <= babs_d;
            dvd_q      <= dvd_d;
            prem_q     <= prem_d;
            cnt_q      <= cnt_d;
            sgn_quot_q <= sgn_quot_d;
            sgn_rem_q  <= sgn_rem_d;
            dbz_pend_q <= dbz_pend_d;
            ovf_pend_q <= ovf_pend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        tc_d       = tc_q;
        babs_d     = babs_q;
        dvd_d      = dvd_q;
        prem_d     = prem_q;
        cnt_d      = cnt_q;
        sgn_quot_d = sgn_quot_q;
        sgn_rem_d  = sgn_rem_q;
        dbz_pend_d = dbz_pend_q;
        ovf_pend_d = ovf_pend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;
        rem_sh     = {prem_q, dvd_q[A_WIDTH-1]};
        trial_ge   = (rem_sh >= {1'b0, babs_q});

        unique case (state_q)
            S_IDLE: begin
                if (i_in_valid) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    tc_d    = i_tc;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                dvd_d      = (tc_q && a_q[A_WIDTH-1]) ? (~a_q + A_WIDTH'(1)) : a_q;
                babs_d     = (tc_q && b_q[B_WIDTH-1]) ? (~b_q + B_WIDTH'(1)) : b_q;
                sgn_quot_d = tc_q && (a_q[A_WIDTH-1] ^ b_q[B_WIDTH-1]);
                sgn_rem_d  = tc_q && a_q[A_WIDTH-1];
                dbz_pend_d = (b_q == '0);
                ovf_pend_d = tc_q && (a_q == A_MIN) && (b_q == B_ONES);
                prem_d     = '0;
                cnt_d      = CNT_W'(A_WIDTH - 1);
                state_d    = S_ITER;
            end
            S_ITER: begin
                // Restoring step: keep the difference only when it does not go negative
                if (trial_ge) begin
                    prem_d = B_WIDTH'(rem_sh - {1'b0, babs_q});
                end else begin
                    prem_d = rem_sh[B_WIDTH-1:0];
                end
                dvd_d = {dvd_q[A_WIDTH-2:0], trial_ge};
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                // Truncating division: remainder follows the dividend's sign
                quot_d = sgn_quot_q ? (~dvd_q + A_WIDTH'(1)) : dvd_q;
                rem_d  = sgn_rem_q ? (~prem_q + B_WIDTH'(1)) : prem_q;
                dbz_d  = dbz_pend_q;
                ovf_d  = ovf_pend_q;
                if (dbz_pend_q) begin
                    quot_d = '1;
                    rem_d  = a_q[B_WIDTH-1:0];
                end else if (ovf_pend_q) begin
                    quot_d = A_MIN;
                    rem_d  = '0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (i_out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_in_ready    = (state_q == S_IDLE);
    assign o_out_valid   = (state_q == S_DONE);
    assign o_quot        = quot_q;
    assign o_rem         = rem_q;
    assign o_div_by_zero = dbz_q;
    assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_div_seq_tc.sv
// tb_div_seq_tc: directed vector table plus hand-written handshake, backpressure and reset sequences.
module tb_div_seq_tc;

    localparam int unsigned AW = 16;
    localparam int unsigned BW = 16;
    localparam int LAT = AW + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          tc;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] quot;
    logic [BW-1:0] rem;
    logic          dbz;
    logic          ovf;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        bit            tc;
        logic [AW-1:0] q;
        logic [BW-1:0] r;
        bit            dbz;
        bit            ovf;
    } vec_t;

    div_seq_tc #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_a          (a),
        .i_b          (b),
        .i_tc         (tc),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_quot       (quot),
        .o_rem        (rem),
        .o_div_by_zero(dbz),
        .o_overflow   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one operation, check latency and result, then hand it off
    task automatic run_op(input string nm, input vec_t v);
        int n;
        @(negedge clk);
        a = v.a; b = v.b; tc = v.tc; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (n < LAT + 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out_valid) break;
        end
        chk({nm, " latency"}, 32'(n), 32'(LAT));
        chk({nm, " quot"}, 32'(quot), 32'(v.q));
        chk({nm, " rem"}, 32'(rem), 32'(v.r));
        chk({nm, " dbz"}, 32'(dbz), 32'(v.dbz));
        chk({nm, " ovf"}, 32'(ovf), 32'(v.ovf));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({nm, " valid drop"}, 32'(out_valid), 32'd0);
        chk({nm, " quot hold"}, 32'(quot), 32'(v.q));
    endtask

    vec_t vecs[16];

    initial begin
        vec_t bp_v;
        int   n;
        bit   seen;
        logic [AW-1:0] q_hold;
        logic [BW-1:0] r_hold;

        vecs[0]  = '{16'h0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 1'b0, 1'b0};
        vecs[1]  = '{16'hFF9C, 16'h0007, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0};
        vecs[2]  = '{16'h0064, 16'hFFF9, 1'b1, 16'hFFF2, 16'h0002, 1'b0, 1'b0};
        vecs[3]  = '{16'hFF9C, 16'hFFF9, 1'b1, 16'h000E, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h04D2, 16'h0000, 1'b0, 16'hFFFF, 16'h04D2, 1'b1, 1'b0};
        vecs[5]  = '{16'h0009, 16'h0003, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1};
        vecs[7]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0};
        vecs[8]  = '{16'h0007, 16'h0064, 1'b0, 16'h0000, 16'h0007, 1'b0, 1'b0};
        vecs[9]  = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        vecs[11] = '{16'h8000, 16'h0002, 1'b1, 16'hC000, 16'h0000, 1'b0, 1'b0};
        vecs[12] = '{16'hFFFF, 16'h00FF, 1'b0, 16'h0101, 16'h0000, 1'b0, 1'b0};
        vecs[13] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0};
        vecs[14] = '{16'hFF9C, 16'h0007, 1'b0, 16'h2484, 16'h0000, 1'b0, 1'b0};
        vecs[15] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8001, 16'h0000, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; tc = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset quot", 32'(quot), 32'd0);
        chk("reset rem", 32'(rem), 32'd0);
        chk("reset flags", 32'({dbz, ovf}), 32'd0);

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: result held for 5 stalled cycles while new operands are ignored
        bp_v = '{16'h03E8, 16'h0021, 1'b0, 16'h001E, 16'h000A, 1'b0, 1'b0};
        @(negedge clk);
        a = bp_v.a; b = bp_v.b; tc = bp_v.tc; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (n < LAT + 20) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        chk("bp reached done", 32'(out_valid), 32'd1);
        q_hold = quot; r_hold = rem;
        chk("bp quot", 32'(q_hold), 32'(bp_v.q));
        chk("bp rem", 32'(r_hold), 32'(bp_v.r));
        a = 16'h1111; b = 16'h0002; tc = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp valid held", 32'(out_valid), 32'd1);
            chk("bp in_ready low", 32'(in_ready), 32'd0);
            chk("bp quot stable", 32'(quot), 32'(bp_v.q));
            chk("bp rem stable", 32'(rem), 32'(bp_v.r));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp handoff valid", 32'(out_valid), 32'd0);
        chk("bp handoff in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("bp stray op ignored", 32'(in_ready), 32'd1);

        // Reset in the middle of an iteration discards the operation
        @(negedge clk);
        a = 16'h0064; b = 16'h0007; tc = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst mid in_ready", 32'(in_ready), 32'd1);
        chk("rst mid out_valid", 32'(out_valid), 32'd0);
        chk("rst mid quot", 32'(quot), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < LAT + 10; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rst mid no result", 32'(seen), 32'd0);
        run_op("post rst", vecs[5]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
